stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Run-level controller that sequences a chain of NUM_STAGES hardware stages over per-stage start/done handshakes.
- A host-side rdy/done handshake brackets each run; the host is the HPS bridge or KEY[0] on the board.
- Enforces a per-stage watchdog, counts completed runs and exposes state, stage index and run count for the display_hex debug readout.
- Sits between the host handshake and the accelerator datapath stages.

Parameters:
- NUM_STAGES, 4, number of sequenced stages (1..16).
- TIMEOUT_CYCLES, 50_000_000, cycles a stage may take before timeout (one second at 50 MHz; >=2).
- STEP_W, 12, width of completed-run counter.

Ports:
- CLOCK_50  in  1  sole clock; all logic on posedge.
- RESET_N  in  1  synchronous, active-low reset.
- rdy  in  1  host request; level, must stay high until done or timeout_err is seen.
- abort  in  1  synchronous cancel of an in-flight run.
- stage_done  in  NUM_STAGES  per-stage completion pulse or level.
- stage_start  out  NUM_STAGES  one-hot start pulse to the current stage.
- done  out  1  run complete; held until rdy drops.
- timeout_err  out  1  run failed on watchdog; held until rdy drops.
- busy  out  1  high in LAUNCH and WAIT.
- state  out  4  encoded FSM state for HEX0.
- stage_idx  out  4  current stage index.
- step_count  out  STEP_W  completed successful runs; wraps.

Behaviour:
- Reset (RESET_N=0 at posedge), any state: state=IDLE, stage_idx=0, timer=0, step_count=0. All outputs are 0.
- Encoding: IDLE=0, LAUNCH=1, WAIT=2, DONE=3, ERROR=4. Values 5..15 are unreachable and recover to IDLE on the next edge.
- IDLE: if rdy=1 and abort=0, then stage_idx<=0 and go to LAUNCH. Otherwise stay.
- LAUNCH (exactly one cycle):
  - stage_start[stage_idx]=1, decoded from the registered state; all other bits are 0.
  - timer<=0; go to WAIT.
  - stage_done is ignored in this cycle.
- WAIT: timer increments each cycle; only stage_done[stage_idx] is observed.
  - If it is 1 and stage_idx==NUM_STAGES-1: go to DONE and step_count<=step_count+1.
  - If it is 1 and stage_idx<NUM_STAGES-1: stage_idx<=stage_idx+1 and go to LAUNCH. This gives a 2-cycle minimum per stage.
  - Else if timer==TIMEOUT_CYCLES-1: go to ERROR.
  - If stage_done and timeout fire in the same cycle, stage_done wins.
- DONE: done=1. When rdy=0, go to IDLE. done stays 1 through the last DONE cycle and drops with the IDLE entry.
- ERROR: timeout_err=1, and stage_idx freezes at the failing stage. When rdy=0, go to IDLE.
- abort=1 in LAUNCH or WAIT:
  - Go to IDLE next edge; stage_idx<=0; no step_count increment.
  - abort takes priority over stage_done and timeout.
  - In LAUNCH, stage_start is still pulsed that cycle.
- abort in IDLE, DONE or ERROR: no effect.
- rdy dropping in LAUNCH or WAIT: ignored; the run continues (protocol violation, not aborted).
- step_count wraps from 2^STEP_W-1 to 0.
- timer width is clog2(TIMEOUT_CYCLES). The timer holds its value outside WAIT.
- Latency:
  - rdy rise to first stage_start: 1 cycle.
  - last stage_done to done=1: 1 cycle.

Test Plan (NUM_STAGES=4, TIMEOUT_CYCLES=16):
- Reset mid-WAIT with stage_idx=2 → next cycle state=0, stage_idx=0, step_count=0, all outputs 0.
- rdy=1, each stage_done returned 3 cycles after its start → stage_start pulses 1,2,4,8 each exactly one cycle; done=1 at cycle 17; step_count=1. rdy=0 → IDLE next edge, done=0.
- Stage 1 never answers → timeout_err=1 after 16 WAIT cycles, stage_idx=1, step_count unchanged. rdy=0 → IDLE.
- stage_done[1] asserted while stage_idx=0, plus stage_done[0] on the same cycle as timer==15 → wrong-stage bit ignored; stage 0 completes and stage_idx becomes 1, no timeout.
- abort on the 2nd WAIT cycle of stage 2 → IDLE next edge, stage_idx=0, step_count unchanged. A following rdy starts again at stage 0.
- Preload step_count to 4095 and complete one run → step_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// Run-level sequencer: walks NUM_STAGES datapath stages over start/done handshakes,
// bracketed by a host rdy/done handshake, with a per-stage watchdog and a run counter.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned STEP_W         = 12
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  rdy,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  busy,
  output logic [3:0]            state,
  output logic [3:0]            stage_idx,
  output logic [STEP_W-1:0]     step_count
);

  localparam int unsigned       TimerW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        LastIdx   = 4'(NUM_STAGES - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StLaunch = 4'd1,
    StWait   = 4'd2,
    StDone   = 4'd3,
    StError  = 4'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          stage_idx_q, stage_idx_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                cur_done;

  // Only the done bit of the stage currently in flight is observed.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      cur_done = cur_done | (stage_done[i] & (stage_idx_q == 4'(i)));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      stage_idx_q <= 4'd0;
      timer_q     <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    timer_d     = timer_q;
    step_d      = step_q;
    case (state_q)
      StIdle: begin
        if (rdy && !abort) begin
          stage_idx_d = 4'd0;
          state_d     = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        if (abort) begin
          stage_idx_d = 4'd0;
          state_d     = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // Priority: abort, then stage completion, then watchdog expiry.
        if (abort) begin
          stage_idx_d = 4'd0;
          state_d     = StIdle;
        end else if (cur_done) begin
          if (stage_idx_q == LastIdx) begin
            step_d  = step_q + 1'b1;
            state_d = StDone;
          end else begin
            stage_idx_d = stage_idx_q + 4'd1;
            state_d     = StLaunch;
          end
        end else if (timer_q == TimerLast) begin
          state_d = StError;
        end
      end
      StDone, StError: begin
        if (!rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stage_start = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      stage_start[i] = (state_q == StLaunch) && (stage_idx_q == 4'(i));
    end
  end

  assign done        = (state_q == StDone);
  assign timeout_err = (state_q == StError);
  assign busy        = (state_q == StLaunch) || (state_q == StWait);
  assign state       = state_q;
  assign stage_idx   = stage_idx_q;
  assign step_count  = step_q;

endmodule
